// File: rtl/dbus_reader_if.sv
// Request/response bundle between a dbus consumer and its controller.
// The master side issues requests and presents the bus level; the slave side is the reader.
interface dbus_reader_if #(
  parameter int unsigned WIDTH = 12
);
  logic             req;
  logic [1:0]       src;
  logic [WIDTH-1:0] dbus;
  logic [3:0]       rd;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output req, src, dbus,
    input  rd, q, busy, done, err
  );

  modport slave (
    input  req, src, dbus,
    output rd, q, busy, done, err
  );
endinterface

// File: rtl/dbus_reader.sv
// Sequenced reader for the open-drain dbus: strobe a source, let the bus settle,
// double-sample for stability and latch the word.
module dbus_reader #(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  dbus_reader_if.slave bus
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned RD_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_S1,
    ST_S2,
    ST_DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SEL_W-1:0] sel_q;
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] q_q;
  logic [RD_W-1:0]  rd_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [RD_W-1:0]  strobe_src_d;
  logic [RD_W-1:0]  strobe_sel_d;

  // One-hot strobe decode; only ever loaded into rd_q, never routed to the port.
  always_comb begin
    strobe_src_d = RD_W'(1) << bus.src;
    strobe_sel_d = RD_W'(1) << sel_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      s1_q    <= '0;
      q_q     <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req) begin
            state_q <= ST_DRIVE;
            sel_q   <= bus.src;
            cnt_q   <= CNT_W'(SETTLE - 1);
            err_q   <= 1'b0;
            rd_q    <= strobe_src_d;
            busy_q  <= 1'b1;
          end
        end
        ST_DRIVE: begin
          rd_q <= strobe_sel_d;
          if (cnt_q == '0) begin
            state_q <= ST_S1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_S1: begin
          rd_q    <= strobe_sel_d;
          s1_q    <= bus.dbus;
          state_q <= ST_S2;
        end
        ST_S2: begin
          // A mismatch between the two samples keeps the old word and flags the read.
          if (bus.dbus == s1_q) begin
            q_q <= bus.dbus;
          end else begin
            err_q <= 1'b1;
          end
          rd_q    <= '0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          rd_q    <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rd   = rd_q;
  assign bus.q    = q_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

  a_rd_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(rd_q))
    else $error("rd strobes not one-hot");
endmodule

// File: tb/tb_dbus_reader.sv
// Scoreboarded bench for dbus_reader: SETTLE=2 instance for most scenarios, SETTLE=1 for the short case.
module tb_dbus_reader;
  localparam int unsigned W = 12;

  typedef struct packed {
    logic [W-1:0] q;
    logic         err;
  } exp_t;

  logic clk;
  logic rst;

  dbus_reader_if #(.WIDTH(W)) ia ();
  dbus_reader_if #(.WIDTH(W)) ib ();

  dbus_reader #(.WIDTH(W), .SETTLE(2)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  dbus_reader #(.WIDTH(W), .SETTLE(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  exp_t         sb_a[$];
  exp_t         sb_b[$];
  exp_t         ea;
  exp_t         eb;
  logic [W-1:0] model_q_a;
  logic [W-1:0] model_q_b;
  int           n_checks;
  int           n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void push_a(input logic [W-1:0] d1, input logic [W-1:0] d2);
    if (d1 == d2) begin
      model_q_a = d1;
      sb_a.push_back('{q: d1, err: 1'b0});
    end else begin
      sb_a.push_back('{q: model_q_a, err: 1'b1});
    end
  endfunction

  // Scoreboard checkers: each done pulse must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (ia.done === 1'b1) begin
      n_checks++;
      if (sb_a.size() == 0) begin
        $display("FAIL sb_a_unexpected_done: done=1 with no read pending, required done=0");
      end else begin
        n_pass++;
        ea = sb_a.pop_front();
        n_checks++;
        if (ia.q !== ea.q) $display("FAIL sb_a_q: q=%h, required %h", ia.q, ea.q);
        else n_pass++;
        n_checks++;
        if (ia.err !== ea.err) $display("FAIL sb_a_err: err=%b, required %b", ia.err, ea.err);
        else n_pass++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (ib.done === 1'b1) begin
      n_checks++;
      if (sb_b.size() == 0) begin
        $display("FAIL sb_b_unexpected_done: done=1 with no read pending, required done=0");
      end else begin
        n_pass++;
        eb = sb_b.pop_front();
        n_checks++;
        if (ib.q !== eb.q) $display("FAIL sb_b_q: q=%h, required %h", ib.q, eb.q);
        else n_pass++;
        n_checks++;
        if (ib.err !== eb.err) $display("FAIL sb_b_err: err=%b, required %b", ib.err, eb.err);
        else n_pass++;
      end
    end
  end

  // One SETTLE=2 read on dut_a: d1 through cycle 3, d2 from cycle 4; checks per-cycle timing.
  task automatic read_a(input logic [1:0] s, input logic [W-1:0] d1, input logic [W-1:0] d2,
                        input string tag);
    logic [3:0] exp_rd;
    exp_rd  = 4'b0001 << s;
    ia.req  = 1'b1;
    ia.src  = s;
    ia.dbus = d1;
    push_a(d1, d2);
    tick;
    ia.req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 4) ia.dbus = d2;
      n_checks++;
      if (ia.rd !== ((c <= 4) ? exp_rd : 4'b0000) || ia.busy !== 1'b1 || ia.done !== (c == 5))
        $display("FAIL %s_cycle%0d: rd=%b busy=%b done=%b, required rd=%b busy=1 done=%b",
                 tag, c, ia.rd, ia.busy, ia.done, (c <= 4) ? exp_rd : 4'b0000, (c == 5));
      else n_pass++;
      if (c == 1) begin
        n_checks++;
        if (ia.err !== 1'b0) $display("FAIL %s_err_cleared: err=%b, required 0", tag, ia.err);
        else n_pass++;
      end
      tick;
    end
    n_checks++;
    if (ia.rd !== 4'b0000 || ia.busy !== 1'b0 || ia.done !== 1'b0)
      $display("FAIL %s_idle: rd=%b busy=%b done=%b, required rd=0000 busy=0 done=0",
               tag, ia.rd, ia.busy, ia.done);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ia.req = 1'b0; ia.src = 2'd0; ia.dbus = '0;
    ib.req = 1'b0; ib.src = 2'd0; ib.dbus = '0;
    model_q_a = '0;
    model_q_b = '0;
    tick;
    tick;
    n_checks++;
    if ({ia.rd, ia.q, ia.busy, ia.done, ia.err} !== '0)
      $display("FAIL reset_a: rd=%b q=%h busy=%b done=%b err=%b, required all 0",
               ia.rd, ia.q, ia.busy, ia.done, ia.err);
    else n_pass++;
    n_checks++;
    if ({ib.rd, ib.q, ib.busy, ib.done, ib.err} !== '0)
      $display("FAIL reset_b: rd=%b q=%h busy=%b done=%b err=%b, required all 0",
               ib.rd, ib.q, ib.busy, ib.done, ib.err);
    else n_pass++;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    read_a(2'd1, 12'hA5C, 12'hA5C, "basic");
  endtask

  task automatic test_unstable;
    read_a(2'd2, 12'h123, 12'h124, "unstable");
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ia.err !== 1'b1 || ia.q !== 12'hA5C)
        $display("FAIL unstable_hold%0d: err=%b q=%h, required err=1 q=a5c", i, ia.err, ia.q);
      else n_pass++;
      tick;
    end
    read_a(2'd1, 12'h0F0, 12'h0F0, "err_clear");
  endtask

  task automatic test_back_to_back;
    logic [1:0] src_r;
    logic [3:0] exp_rd;
    int         r;
    int         p;
    ia.req  = 1'b1;
    ia.src  = 2'd0;
    ia.dbus = 12'h3C3;
    for (int i = 0; i < 3; i++) push_a(12'h3C3, 12'h3C3);
    tick;
    for (int k = 1; k <= 18; k++) begin
      if (k >= 13) ia.req = 1'b0;
      ia.src = (k == 6) ? 2'd3 : (k == 12) ? 2'd0 : ((k % 2) == 1) ? 2'd1 : 2'd2;
      r      = (k - 1) / 6;
      p      = (k - 1) % 6;
      src_r  = (r == 1) ? 2'd3 : 2'd0;
      exp_rd = (p < 4) ? (4'b0001 << src_r) : 4'b0000;
      n_checks++;
      if (ia.rd !== exp_rd || ia.done !== (p == 4) || ia.busy !== (p != 5) || !$onehot0(ia.rd))
        $display("FAIL b2b_cycle%0d: rd=%b done=%b busy=%b, required rd=%b done=%b busy=%b",
                 k, ia.rd, ia.done, ia.busy, exp_rd, (p == 4), (p != 5));
      else n_pass++;
      tick;
    end
    n_checks++;
    if (ia.rd !== 4'b0000 || ia.busy !== 1'b0)
      $display("FAIL b2b_no_fourth: rd=%b busy=%b, required rd=0000 busy=0", ia.rd, ia.busy);
    else n_pass++;
  endtask

  task automatic test_req_while_busy;
    int dones;
    dones   = 0;
    ia.req  = 1'b1;
    ia.src  = 2'd0;
    ia.dbus = 12'h5A5;
    push_a(12'h5A5, 12'h5A5);
    tick;
    ia.req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin ia.req = 1'b1; ia.src = 2'd2; end
      if (k == 3) begin ia.req = 1'b0; ia.src = 2'd0; end
      if (ia.done === 1'b1) dones++;
      n_checks++;
      if (ia.rd !== ((k <= 4) ? 4'b0001 : 4'b0000) || ia.busy !== (k <= 5))
        $display("FAIL busy_req_cycle%0d: rd=%b busy=%b, required rd=%b busy=%b",
                 k, ia.rd, ia.busy, (k <= 4) ? 4'b0001 : 4'b0000, (k <= 5));
      else n_pass++;
      tick;
    end
    n_checks++;
    if (dones != 1) $display("FAIL busy_req_dones: saw %0d done pulses, required 1", dones);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    ia.req  = 1'b1;
    ia.src  = 2'd1;
    ia.dbus = 12'h777;
    tick;
    ia.req = 1'b0;
    tick;
    tick;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (ia.rd !== 4'b0000 || ia.busy !== 1'b0 || ia.q !== '0 || ia.done !== 1'b0)
      $display("FAIL reset_mid_async: rd=%b busy=%b q=%h done=%b, required all 0",
               ia.rd, ia.busy, ia.q, ia.done);
    else n_pass++;
    model_q_a = '0;
    model_q_b = '0;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_checks++;
      if (ia.done !== 1'b0 || ia.busy !== 1'b0)
        $display("FAIL reset_mid_hold%0d: done=%b busy=%b, required 0 0", i, ia.done, ia.busy);
      else n_pass++;
    end
    rst = 1'b0;
    tick;
    read_a(2'd1, 12'h777, 12'h777, "post_reset");
  endtask

  task automatic test_settle1;
    ib.req  = 1'b1;
    ib.src  = 2'd3;
    ib.dbus = 12'hFFF;
    model_q_b = 12'hFFF;
    sb_b.push_back('{q: 12'hFFF, err: 1'b0});
    tick;
    ib.req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      n_checks++;
      if (ib.rd !== ((k <= 3) ? 4'b1000 : 4'b0000) || ib.done !== (k == 4) || ib.busy !== (k <= 4))
        $display("FAIL settle1_cycle%0d: rd=%b done=%b busy=%b, required rd=%b done=%b busy=%b",
                 k, ib.rd, ib.done, ib.busy, (k <= 3) ? 4'b1000 : 4'b0000, (k == 4), (k <= 4));
      else n_pass++;
      tick;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_unstable();
    test_back_to_back();
    test_req_while_busy();
    test_reset_mid();
    test_settle1();
    tick;
    n_checks++;
    if (sb_a.size() != 0) $display("FAIL sb_a_drain: %0d reads without done, required 0", sb_a.size());
    else n_pass++;
    n_checks++;
    if (sb_b.size() != 0) $display("FAIL sb_b_drain: %0d reads without done, required 0", sb_b.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end
endmodule
